// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: load formats, register-zero constant and the
// MEM/WB pipeline register layout.
package mips_pkg;

  typedef enum logic [1:0] {
    LM_WORD   = 2'b00,
    LM_HALF_S = 2'b01,
    LM_BYTE_S = 2'b10,
    LM_BYTE_U = 2'b11
  } load_mode_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    load_mode_t  load_mode;
    logic [31:0] alu_result;
    logic [31:0] mem_read_data;
    logic [4:0]  write_register;
  } memwb_t;

endpackage

// File: rtl/wb_load_extract.sv
// Sub-word load formatter: picks the little-endian lane addressed by i_addr
// and sign- or zero-extends it according to the load mode.
module wb_load_extract
  import mips_pkg::*;
(
  input  logic [31:0] i_raw,
  input  logic [1:0]  i_addr,
  input  load_mode_t  i_load_mode,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_raw[7:0];
    unique case (i_addr)
      2'd0: w_byte = i_raw[7:0];
      2'd1: w_byte = i_raw[15:8];
      2'd2: w_byte = i_raw[23:16];
      2'd3: w_byte = i_raw[31:24];
      default: w_byte = i_raw[7:0];
    endcase
    // Halfword alignment ignores addr[0].
    w_half = i_addr[1] ? i_raw[31:16] : i_raw[15:0];
  end

  always_comb begin
    o_data = i_raw;
    unique case (i_load_mode)
      LM_WORD:   o_data = i_raw;
      LM_HALF_S: o_data = {{16{w_half[15]}}, w_half};
      LM_BYTE_S: o_data = {{24{w_byte[7]}}, w_byte};
      LM_BYTE_U: o_data = {24'd0, w_byte};
      default:   o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, load/ALU write mux, $0 write mask,
// retired-instruction counter. Define WB_FWD_EN to add the forwarding tap.
module wb_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_stall,
  input  logic             in_flush,
  input  logic             in_valid,
  input  logic             in_RegWrite,
  input  logic             in_MemToReg,
  input  logic [1:0]       in_load_mode,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_mem_read_data,
  input  logic [4:0]       in_write_register,
  output logic [4:0]       out_write_register,
  output logic [31:0]      out_write_data,
  output logic             out_RegWrite,
  output logic [CNT_W-1:0] retired_count
`ifdef WB_FWD_EN
  ,
  output logic             fwd_valid,
  output logic [4:0]       fwd_register,
  output logic [31:0]      fwd_data
`endif
);

  memwb_t           r_memwb;
  memwb_t           w_next;
  logic [CNT_W-1:0] r_retired;
  logic [31:0]      w_load_data;

  always_comb begin
    w_next                = '0;
    w_next.valid          = in_valid;
    w_next.reg_write      = in_RegWrite;
    w_next.mem_to_reg     = in_MemToReg;
    w_next.load_mode      = load_mode_t'(in_load_mode);
    w_next.alu_result     = in_alu_result;
    w_next.mem_read_data  = in_mem_read_data;
    w_next.write_register = in_write_register;
  end

  // Flush outranks stall; flushed fields are cleared so the port stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memwb <= '0;
    end else if (in_flush) begin
      r_memwb <= '0;
    end else if (!in_stall) begin
      r_memwb <= w_next;
    end
  end

  // An instruction retires when it leaves WB, i.e. valid and not held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (r_memwb.valid && !in_stall) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  wb_load_extract u_load_extract (
    .i_raw       (r_memwb.mem_read_data),
    .i_addr      (r_memwb.alu_result[1:0]),
    .i_load_mode (r_memwb.load_mode),
    .o_data      (w_load_data)
  );

  assign out_write_register = r_memwb.write_register;
  assign out_write_data     = r_memwb.mem_to_reg ? w_load_data : r_memwb.alu_result;
  assign out_RegWrite       = r_memwb.valid & r_memwb.reg_write &
                              (r_memwb.write_register != REG_ZERO);
  assign retired_count      = r_retired;

`ifdef WB_FWD_EN
  assign fwd_valid    = out_RegWrite;
  assign fwd_register = out_write_register;
  assign fwd_data     = out_write_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (counter narrowed to 4 bits to exercise
// wrap). Builds with or without WB_FWD_EN.
module tb_wb_stage;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_stall;
  logic             in_flush;
  logic             in_valid;
  logic             in_RegWrite;
  logic             in_MemToReg;
  logic [1:0]       in_load_mode;
  logic [31:0]      in_alu_result;
  logic [31:0]      in_mem_read_data;
  logic [4:0]       in_write_register;
  logic [4:0]       out_write_register;
  logic [31:0]      out_write_data;
  logic             out_RegWrite;
  logic [CNT_W-1:0] retired_count;
`ifdef WB_FWD_EN
  logic             fwd_valid;
  logic [4:0]       fwd_register;
  logic [31:0]      fwd_data;
`endif

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_stall           (in_stall),
    .in_flush           (in_flush),
    .in_valid           (in_valid),
    .in_RegWrite        (in_RegWrite),
    .in_MemToReg        (in_MemToReg),
    .in_load_mode       (in_load_mode),
    .in_alu_result      (in_alu_result),
    .in_mem_read_data   (in_mem_read_data),
    .in_write_register  (in_write_register),
    .out_write_register (out_write_register),
    .out_write_data     (out_write_data),
    .out_RegWrite       (out_RegWrite),
    .retired_count      (retired_count)
`ifdef WB_FWD_EN
    ,
    .fwd_valid          (fwd_valid),
    .fwd_register       (fwd_register),
    .fwd_data           (fwd_data)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  bit          m_valid, m_rw, m_mtr;
  logic [1:0]  m_mode;
  logic [31:0] m_alu, m_raw;
  logic [4:0]  m_wr;
  int unsigned m_count;

  function automatic logic [31:0] fmt_load(input logic [31:0] raw, input logic [1:0] addr,
                                           input logic [1:0] mode);
    logic [31:0] h, b;
    h = (raw >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
    b = (raw >> (8 * int'(addr))) & 32'h0000_00FF;
    case (mode)
      2'd0: return raw;
      2'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      2'd2: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      default: return b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mtr = 0; m_mode = 2'd0;
    m_alu = '0; m_raw = '0; m_wr = '0; m_count = 0;
  endtask

  task automatic check_outputs(input string tag);
    bit          exp_we;
    logic [31:0] exp_data;
    exp_we   = m_valid && m_rw && (m_wr != 5'd0);
    exp_data = m_mtr ? fmt_load(m_raw, m_alu[1:0], m_mode) : m_alu;
    check({tag, ".regwrite"}, {31'd0, out_RegWrite}, {31'd0, exp_we});
    if (m_valid) begin
      check({tag, ".wreg"}, {27'd0, out_write_register}, {27'd0, m_wr});
      check({tag, ".wdata"}, out_write_data, exp_data);
    end
    check({tag, ".count"}, {28'd0, retired_count}, m_count % (1 << CNT_W));
`ifdef WB_FWD_EN
    check({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, exp_we});
    check({tag, ".fwd_reg"}, {27'd0, fwd_register}, {27'd0, out_write_register});
    check({tag, ".fwd_data"}, fwd_data, out_write_data);
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a negedge: drive one MEM-stage slot, advance the model across
  // the next rising edge, then check at the following negedge.
  task automatic drive_cycle(input string tag, input bit v, input bit rw, input bit mtr,
                             input logic [1:0] mode, input logic [31:0] alu,
                             input logic [31:0] raw, input logic [4:0] wr,
                             input bit stall, input bit flush);
    in_valid = v; in_RegWrite = rw; in_MemToReg = mtr; in_load_mode = mode;
    in_alu_result = alu; in_mem_read_data = raw; in_write_register = wr;
    in_stall = stall; in_flush = flush;
    if (m_valid && !stall) m_count++;
    if (flush) m_valid = 0;
    else if (!stall) begin
      m_valid = v; m_rw = rw; m_mtr = mtr; m_mode = mode;
      m_alu = alu; m_raw = raw; m_wr = wr;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic drive_idle(input string tag);
    drive_cycle(tag, 0, 0, 0, 2'd0, 32'd0, 32'd0, 5'd0, 0, 0);
  endtask

  task automatic drive_random(input string tag, input bit allow_ctrl);
    bit st, fl;
    st = allow_ctrl && ($urandom_range(0, 4) == 0);
    fl = allow_ctrl && ($urandom_range(0, 9) == 0);
    drive_cycle(tag, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom, $urandom,
                ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), st, fl);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] raw_k;
    logic [1:0]  modes[4];
    raw_k = 32'h1285_3456;
    modes = '{2'd2, 2'd3, 2'd1, 2'd0};

    rst_n = 1'b0;
    in_stall = 0; in_flush = 0; in_valid = 0; in_RegWrite = 0; in_MemToReg = 0;
    in_load_mode = 2'd0; in_alu_result = '0; in_mem_read_data = '0; in_write_register = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.regwrite", {31'd0, out_RegWrite}, 32'd0);
    check("reset.wreg", {27'd0, out_write_register}, 32'd0);
    check("reset.wdata", out_write_data, 32'd0);
    check("reset.count", {28'd0, retired_count}, 32'd0);
    rst_n = 1'b1;

    // Sub-word load formats from one raw word at byte address 2.
    exp_q.push_back(32'hFFFF_FF85);
    exp_q.push_back(32'h0000_0085);
    exp_q.push_back(32'h0000_1285);
    exp_q.push_back(32'h1285_3456);
    foreach (modes[i]) begin
      drive_cycle("load", 1, 1, 1, modes[i], 32'h0000_1002, raw_k, 5'd7, 0, 0);
      check("load.const", out_write_data, exp_q.pop_front());
      check("load.we", {31'd0, out_RegWrite}, 32'd1);
    end

    // ALU write to $0: suppressed, but still retires.
    drive_cycle("zero", 1, 1, 0, 2'd0, 32'hDEAD_BEEF, 32'd0, 5'd0, 0, 0);
    check("zero.we", {31'd0, out_RegWrite}, 32'd0);
    drive_idle("zero.retire");
    check("zero.count", {28'd0, retired_count}, 32'd5);

    // Stall three cycles with changing inputs, then stall+flush.
    drive_cycle("pre_stall", 1, 1, 0, 2'd0, 32'hCAFE_0001, 32'd0, 5'd9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle("stall", 1, 1, 1, 2'd3, $urandom, $urandom, 5'd3, 1, 0);
      check("stall.hold", out_write_data, 32'hCAFE_0001);
    end
    drive_cycle("stall_flush", 1, 1, 0, 2'd0, 32'h1111_1111, 32'd0, 5'd4, 1, 1);
    check("flush.we", {31'd0, out_RegWrite}, 32'd0);
    check("flush.count", {28'd0, retired_count}, 32'd5);
    drive_idle("post_flush");

    // Randomised traffic with stalls and flushes.
    for (int i = 0; i < 300; i++) drive_random("rand", 1);

    // Asynchronous reset mid-cycle with a write in flight.
    drive_cycle("pre_rst", 1, 1, 0, 2'd0, 32'h5555_AAAA, 32'd0, 5'd12, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.regwrite", {31'd0, out_RegWrite}, 32'd0);
    check("arst.wreg", {27'd0, out_write_register}, 32'd0);
    check("arst.wdata", out_write_data, 32'd0);
    check("arst.count", {28'd0, retired_count}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap: 17 retirements on a 4-bit counter leaves 1.
    for (int i = 0; i < 17; i++)
      drive_cycle("wrap.fill", 1, 1, 0, 2'd0, $urandom, $urandom, 5'($urandom_range(1, 31)), 0, 0);
    drive_idle("wrap.drain");
    check("wrap.count", {28'd0, retired_count}, 32'd1);

    for (int i = 0; i < 100; i++) drive_random("rand2", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline: holds the MEM/WB pipeline register, selects between ALU result and load data, and formats sub-word loads according to `load_mode`. It drives the register-file write port of the decode stage: `write_register`, `write_data` and `RegWrite`. It also keeps a retired-instruction counter and, when configured, a forwarding tap for hazard logic.

## Interface
- `CNT_W`, 32, width of retired-instruction counter
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_stall`  in  1  hold MEM/WB register contents
- `in_flush`  in  1  invalidate MEM/WB register on next edge
- `in_valid`  in  1  MEM stage presents a real instruction
- `in_RegWrite`  in  1  instruction writes a register
- `in_MemToReg`  in  1  1 = write load data, 0 = write ALU result
- `in_load_mode`  in  2  sub-word load format (see Operation)
- `in_alu_result`  in  32  ALU result / effective address
- `in_mem_read_data`  in  32  raw word from data memory
- `in_write_register`  in  5  destination register number
- `out_write_register`  out  5  to decode-stage register file
- `out_write_data`  out  32  to decode-stage register file
- `out_RegWrite`  out  1  to decode-stage register file
- `retired_count`  out  CNT_W  valid instructions retired
- `fwd_valid`, `fwd_register[4:0]`, `fwd_data[31:0]`  out  forwarding tap, present only with `WB_FWD_EN`

## Operation
- MEM/WB register fields: valid, RegWrite, MemToReg, load_mode, alu_result, mem_read_data, write_register.
- Per edge, priority order: flush first (valid←0, other fields don't-care), then stall (hold all fields), otherwise capture all inputs.
- `load_mode` encoding: 00 word; 01 halfword sign-extended; 10 byte sign-extended; 11 byte zero-extended.
- Lane select: little-endian on alu_result[1:0]. Byte lane n = bits [8n+7:8n]. Halfword uses alu_result[1]. Misaligned bit alu_result[0] is ignored for halfword, and bits [1:0] are ignored for word.
- `out_write_data` = MemToReg ? formatted load : alu_result. Formatting is applied only when MemToReg=1.
- `out_RegWrite` = valid & RegWrite & (write_register != 0). Writes to $0 are suppressed.
- `out_write_register` = registered write_register, unmasked.
- `retired_count` increments by 1 on each edge where the registered valid=1 and the stage is not stalled. It wraps modulo 2^CNT_W without saturating.

## Timing
- Latency: one cycle from MEM inputs to write-port outputs. The outputs are combinational from the MEM/WB register.
- The register-file write occurs on the edge after the data appears. The decode stage samples `out_*` on the same clk edge.
- Reset (async, any time): valid←0, all fields←0, `retired_count`←0. Consequently `out_RegWrite`=0, `out_write_register`=0, `out_write_data`=0, and `fwd_valid`=0.
- Deasserting reset mid-stream: the first capture happens on the first rising edge with rst_n=1.
- Stall+flush together: flush wins, and the counter does not increment on that edge.
- Stall held N cycles: outputs remain stable, and `out_RegWrite` may stay high (re-writing the same value is harmless).

## Configuration
- `WB_FWD_EN` defined: `fwd_valid`=`out_RegWrite`, `fwd_register`=`out_write_register`, `fwd_data`=`out_write_data`. These let hazard logic bypass write-before-read in decode.
- `WB_FWD_EN` undefined: the fwd ports and their logic are absent from the module.

## Structure
- Shared package `mips_pkg`: `load_mode_t` enum (LM_WORD, LM_HALF_S, LM_BYTE_S, LM_BYTE_U), `REG_ZERO` constant, and a MEM/WB field struct.
- Sub-module `wb_load_extract`: combinational, taking (raw word, addr[1:0], load_mode) and producing the formatted 32-bit word.
- Top level contains the pipeline register, write mux, $0 mask, counter, and the optional forwarding tap.

## Test plan
- Reset mid-stream with valid writes in flight → all outputs 0 immediately (asynchronous), and `retired_count`=0.
- Load, MemToReg=1, mode 10, addr[1:0]=2, raw 0x12_85_34_56 → next cycle write_data=0xFFFFFF85 and RegWrite=1.
- Same raw word with mode 11 → 0x00000085. Mode 01 with addr=2 → 0x00001285. Mode 00 → 0x12853456.
- ALU op with write_register=0 and RegWrite=1 → `out_RegWrite`=0, but `retired_count` still increments.
- Stall 3 cycles followed by stall+flush → outputs held for 3 cycles, then valid=0, and the count is unchanged across the flush edge.
- Counter with CNT_W=4: retire 17 valid instructions from reset → `retired_count`=1 (wrap). With `WB_FWD_EN`, the fwd ports mirror the write port every cycle.
